reg_ring_master: RTL and testbench
==================================

REG_RING_MASTER -- requirements
Module: reg_ring_master

Interface
REQ-001 SHALL have parameter UDP_REG_SRC_WIDTH, default 2, width of the ring source tag.
REQ-002 SHALL have parameter SRC_ID, default 0, tag stamped on issued requests and matched on return.
REQ-003 SHALL have parameter TIMEOUT, default 255, the number of WAIT cycles before a transaction is abandoned.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- core_reg_req  in  1  one-cycle request pulse from the core.
- core_reg_rd_wr_L  in  1  1 = read, 0 = write.
- core_reg_addr  in  `UDP_REG_ADDR_WIDTH (23)  target address.
- core_reg_wr_data  in  `CPCI_NF2_DATA_WIDTH (32)  write data.
- core_reg_busy  out  1  high from acceptance until completion.
- core_reg_ack  out  1  one-cycle completion pulse.
- core_reg_rd_data  out  32  read data, valid with core_reg_ack.
- core_reg_err  out  1  with ack: no block claimed the access.
- core_reg_timeout  out  1  with ack: the request never returned.
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  ring head.
- reg_addr_out  out  23  ring head.
- reg_data_out  out  32  ring head.
- reg_src_out  out  UDP_REG_SRC_WIDTH  ring head.
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  ring tail.
- reg_addr_in  in  23  ring tail.
- reg_data_in  in  32  ring tail.
- reg_src_in  in  UDP_REG_SRC_WIDTH  ring tail.

Function
REQ-005 SHALL implement the states IDLE, ISSUE, WAIT and DONE.
REQ-006 IDLE: when core_reg_req=1, the block SHALL latch rd_wr_L, addr and wr_data, assert core_reg_busy and go to ISSUE on the next edge.
REQ-007 ISSUE: the block SHALL drive reg_req_out=1, reg_ack_out=0 and the latched fields with reg_src_out=SRC_ID for exactly one cycle, then go to WAIT; req_out rises one cycle after the accepted core_reg_req.
REQ-008 When not issuing, all ring outputs SHALL be 0.
REQ-009 WAIT: a return is reg_req_in=1, reg_src_in=SRC_ID and reg_addr_in equal to the latched address; on a return the block SHALL capture reg_ack_in and reg_data_in and go to DONE.
REQ-010 reg_req_in with a non-matching src or addr, or any reg_req_in outside WAIT, SHALL be discarded with no state change.
REQ-011 DONE: the block SHALL pulse core_reg_ack for one cycle, deassert core_reg_busy and return to IDLE; ack follows the return cycle by exactly one cycle.
REQ-012 Return with reg_ack_in=1: core_reg_rd_data SHALL equal the captured data for reads and 0 for writes, with core_reg_err=0.
REQ-013 Return with reg_ack_in=0: core_reg_err SHALL be 1 and core_reg_rd_data SHALL be 32'hDEAD_BEEF.
REQ-014 core_reg_req while busy SHALL be ignored, with no queueing.
REQ-015 The next request SHALL be accepted no earlier than the cycle after core_reg_ack; throughput is one transaction per ring round trip plus 2 cycles.
REQ-016 core_reg_rd_data, core_reg_err and core_reg_timeout SHALL hold their values until the next core_reg_ack.

Reset
REQ-017 On reset=0, the block SHALL asynchronously force state IDLE, the timeout counter to 0 and every output and latched field to 0.
REQ-018 Reset mid-transaction SHALL abandon the access with no core_reg_ack; a late return after reset release SHALL be discarded per REQ-010.

Configuration
REQ-019 With REG_RING_MASTER_TIMEOUT_EN defined, an 8+ bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-020 When that counter reaches TIMEOUT with no return, the block SHALL go to DONE with core_reg_timeout=1, core_reg_err=1 and rd_data 32'hDEAD_BEEF.
REQ-021 A return in the same cycle the counter reaches TIMEOUT SHALL win, with timeout=0.
REQ-022 A return arriving after a timeout SHALL be discarded.
REQ-023 Without REG_RING_MASTER_TIMEOUT_EN, WAIT SHALL persist until a return, no counter logic SHALL exist and core_reg_timeout SHALL be tied 0.

Verification
REQ-024 Read, loopback with 3-cycle delay, responder sets ack=1 and data=32'h1234_5678 -> req_out at cycle N+1, core_reg_ack at N+5, rd_data=32'h1234_5678, err=0.
REQ-025 Write addr=23'h400010, data=32'hA5A5_A5A5, responder acks -> ring carries the exact addr/data with src=SRC_ID and rd_wr_L=0; ack with rd_data=0.
REQ-026 Return with reg_ack_in=0 -> ack with err=1 and rd_data=32'hDEAD_BEEF.
REQ-027 TIMEOUT_EN, TIMEOUT=16, no return -> ack 17 cycles after req_out with timeout=1; a return injected 5 cycles later is ignored and busy stays 0.
REQ-028 Foreign-src return, then core_reg_req pulses while busy, then matching return -> exactly one ack, matching the latched request.
REQ-029 reset=0 asserted 2 cycles into WAIT -> all outputs 0 immediately; the subsequent return produces no ack.

Source files
------------

// File: rtl/reg_ring_master.sv
// reg_ring_master: issues one core register access at a time onto the
// register ring and returns the ring's answer to the core.
//
// Ports:
//   clk, reset (async, active low)
//   core_reg_*  : core side. One-cycle req in; busy, one-cycle ack,
//                 rd_data/err/timeout out. Result outputs hold until
//                 the next ack.
//   reg_*_out   : ring head. Non-zero only in the single issue cycle.
//   reg_*_in    : ring tail. A return needs req, our src tag and the
//                 latched address.
//
// Optional feature: define REG_RING_MASTER_TIMEOUT_EN to abandon a
// transaction after TIMEOUT wait cycles (reported as err + timeout).
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module reg_ring_master #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID            = 0,
  parameter int TIMEOUT           = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             core_reg_req,
  input  logic                             core_reg_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]   core_reg_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  core_reg_wr_data,
  output logic                             core_reg_busy,
  output logic                             core_reg_ack,
  output logic [31:0]                      core_reg_rd_data,
  output logic                             core_reg_err,
  output logic                             core_reg_timeout,
  output logic                             reg_req_out,
  output logic                             reg_ack_out,
  output logic                             reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_out,
  input  logic                             reg_req_in,
  input  logic                             reg_ack_in,
  input  logic                             reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_in
);

  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [UDP_REG_SRC_WIDTH-1:0] W_SRC =
    UDP_REG_SRC_WIDTH'(SRC_ID);
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  logic [1:0]    r_state;
  logic          r_rd_wr_L;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wr_data;
  logic [31:0]   r_rd_data;
  logic          r_err;

  logic w_issue;
  logic w_wait;
  logic w_match;
  logic w_expire;
  logic w_unused;

  assign w_issue = (r_state == S_ISSUE);
  assign w_wait  = (r_state == S_WAIT);

  // Only a return carrying our tag and the address we sent counts;
  // anything else on the tail is traffic for someone else.
  assign w_match = w_wait && reg_req_in &&
                   (reg_src_in == W_SRC) &&
                   (reg_addr_in == r_addr);

  assign w_unused = reg_rd_wr_L_in;

`ifdef REG_RING_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  // Expire in the wait cycle whose increment would reach TIMEOUT.
  // A return in that same cycle takes priority.
  assign w_expire = w_wait && !w_match &&
                    (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= '0;
    end else if (w_wait) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout <= 1'b0;
    end else if (w_match) begin
      r_timeout <= 1'b0;
    end else if (w_expire) begin
      r_timeout <= 1'b1;
    end
  end

  assign core_reg_timeout = r_timeout;
`else
  localparam int unused_timeout = TIMEOUT;

  assign w_expire         = 1'b0;
  assign core_reg_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rd_wr_L <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (core_reg_req) begin
            r_rd_wr_L <= core_reg_rd_wr_L;
            r_addr    <= core_reg_addr;
            r_wr_data <= core_reg_wr_data;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_match) begin
            r_state <= S_DONE;
            if (reg_ack_in) begin
              r_rd_data <= r_rd_wr_L ? reg_data_in : '0;
              r_err     <= 1'b0;
            end else begin
              r_rd_data <= BAD_DATA;
              r_err     <= 1'b1;
            end
          end else if (w_expire) begin
            r_state   <= S_DONE;
            r_rd_data <= BAD_DATA;
            r_err     <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign core_reg_busy    = (r_state != S_IDLE);
  assign core_reg_ack     = (r_state == S_DONE);
  assign core_reg_rd_data = r_rd_data;
  assign core_reg_err     = r_err;

  // Ring head is quiet except for the single issue cycle.
  assign reg_req_out     = w_issue;
  assign reg_ack_out     = 1'b0;
  assign reg_rd_wr_L_out = w_issue & r_rd_wr_L;
  assign reg_addr_out    = w_issue ? r_addr : '0;
  assign reg_data_out    = w_issue ? r_wr_data : '0;
  assign reg_src_out     = w_issue ? W_SRC : '0;

endmodule

// File: tb/tb_reg_ring_master.sv
// Bench for reg_ring_master: directed transactions, expected acks queued
// by the stimulus and checked by an independent ack monitor.
module tb_reg_ring_master;

  localparam int SW  = 2;
  localparam int SID = 1;
  localparam int TO  = 16;

  logic        clk;
  logic        reset;
  logic        core_reg_req;
  logic        core_reg_rd_wr_L;
  logic [22:0] core_reg_addr;
  logic [31:0] core_reg_wr_data;
  logic        core_reg_busy;
  logic        core_reg_ack;
  logic [31:0] core_reg_rd_data;
  logic        core_reg_err;
  logic        core_reg_timeout;
  logic        reg_req_out;
  logic        reg_ack_out;
  logic        reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [SW-1:0] reg_src_out;
  logic        reg_req_in;
  logic        reg_ack_in;
  logic        reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [SW-1:0] reg_src_in;

  reg_ring_master #(
    .UDP_REG_SRC_WIDTH(SW),
    .SRC_ID(SID),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_reg_req(core_reg_req),
    .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr),
    .core_reg_wr_data(core_reg_wr_data),
    .core_reg_busy(core_reg_busy),
    .core_reg_ack(core_reg_ack),
    .core_reg_rd_data(core_reg_rd_data),
    .core_reg_err(core_reg_err),
    .core_reg_timeout(core_reg_timeout),
    .reg_req_out(reg_req_out),
    .reg_ack_out(reg_ack_out),
    .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out),
    .reg_data_out(reg_data_out),
    .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in),
    .reg_ack_in(reg_ack_in),
    .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in),
    .reg_data_in(reg_data_in),
    .reg_src_in(reg_src_in)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ack(int c, logic [31:0] d, logic e, logic t);
    exp_t x;
    x.cyc  = c;
    x.data = d;
    x.err  = e;
    x.to   = t;
    q.push_back(x);
  endtask

  // Ack monitor: every ack must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (core_reg_ack === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 64'(cyc), 64'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(e.cyc));
          chk("ack_rd_data", 64'(core_reg_rd_data), 64'(e.data));
          chk("ack_err", 64'(core_reg_err), 64'(e.err));
          chk("ack_timeout", 64'(core_reg_timeout), 64'(e.to));
          chk("ack_busy", 64'(core_reg_busy), 64'd1);
        end
      end
    end
  end

  // Drives a request at cycle N, checks the ring head at N+1 and the
  // quiet head at N+2. Returns N; leaves the bench at cycle N+2.
  task automatic issue(input logic rw, input logic [22:0] a,
                       input logic [31:0] d, output int n);
    n = cyc;
    core_reg_req     = 1'b1;
    core_reg_rd_wr_L = rw;
    core_reg_addr    = a;
    core_reg_wr_data = d;
    tick();
    core_reg_req = 1'b0;
    chk("req_out", 64'(reg_req_out), 64'd1);
    chk("ack_out", 64'(reg_ack_out), 64'd0);
    chk("rd_wr_L_out", 64'(reg_rd_wr_L_out), 64'(rw));
    chk("addr_out", 64'(reg_addr_out), 64'(a));
    chk("data_out", 64'(reg_data_out), 64'(d));
    chk("src_out", 64'(reg_src_out), 64'(SID));
    chk("busy_issue", 64'(core_reg_busy), 64'd1);
    tick();
    chk("req_out_quiet", 64'(reg_req_out), 64'd0);
    chk("addr_out_quiet", 64'(reg_addr_out), 64'd0);
  endtask

  task automatic ret(input logic [SW-1:0] s, input logic [22:0] a,
                     input logic ak, input logic [31:0] d);
    reg_req_in  = 1'b1;
    reg_src_in  = s;
    reg_addr_in = a;
    reg_ack_in  = ak;
    reg_data_in = d;
    tick();
    reg_req_in  = 1'b0;
    reg_src_in  = '0;
    reg_addr_in = '0;
    reg_ack_in  = 1'b0;
    reg_data_in = '0;
  endtask

  // Full transaction; the matching return arrives `dly` cycles after
  // req_out, so the ack is due at N + dly + 2.
  task automatic txn(input logic rw, input logic [22:0] a,
                     input logic [31:0] wd, input int dly,
                     input logic ak, input logic [31:0] rdi,
                     input logic [31:0] er, input logic ee);
    int n;
    issue(rw, a, wd, n);
    expect_ack(n + dly + 2, er, ee, 1'b0);
    repeat (dly - 1) tick();
    ret(SW'(SID), a, ak, rdi);
    tick();
    chk("busy_after", 64'(core_reg_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset            = 1'b0;
    core_reg_req     = 1'b0;
    core_reg_rd_wr_L = 1'b0;
    core_reg_addr    = '0;
    core_reg_wr_data = '0;
    reg_req_in       = 1'b0;
    reg_ack_in       = 1'b0;
    reg_rd_wr_L_in   = 1'b0;
    reg_addr_in      = '0;
    reg_data_in      = '0;
    reg_src_in       = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(core_reg_busy), 64'd0);
    chk("rst_ack", 64'(core_reg_ack), 64'd0);
    chk("rst_rd_data", 64'(core_reg_rd_data), 64'd0);
    chk("rst_err", 64'(core_reg_err), 64'd0);
    chk("rst_timeout", 64'(core_reg_timeout), 64'd0);
    chk("rst_req_out", 64'(reg_req_out), 64'd0);
    chk("rst_data_out", 64'(reg_data_out), 64'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Read, 3-cycle loopback: ack at N+5.
    txn(1'b1, 23'h000123, 32'h0, 3, 1'b1, 32'h1234_5678,
        32'h1234_5678, 1'b0);

    // Write: ring carries addr/data, ack returns zero data.
    txn(1'b0, 23'h400010, 32'hA5A5_A5A5, 2, 1'b1, 32'hFFFF_0000,
        32'h0, 1'b0);

    // Nobody claims the access.
    txn(1'b1, 23'h000200, 32'h0, 4, 1'b0, 32'h0102_0304,
        32'hDEAD_BEEF, 1'b1);
    repeat (3) tick();
    chk("hold_rd_data", 64'(core_reg_rd_data), 64'hDEAD_BEEF);
    chk("hold_err", 64'(core_reg_err), 64'd1);

    // Stray return while idle is dropped.
    ret(SW'(SID), 23'h000200, 1'b1, 32'h5555_5555);
    tick();
    chk("idle_stray_busy", 64'(core_reg_busy), 64'd0);

    // Foreign src, wrong addr, and a core req while busy; one ack.
    issue(1'b1, 23'h0000AA, 32'h0, n);
    ret(SW'(2), 23'h0000AA, 1'b1, 32'h1111_1111);
    core_reg_req  = 1'b1;
    core_reg_addr = 23'h0000BB;
    ret(SW'(SID), 23'h0000AB, 1'b1, 32'h2222_2222);
    core_reg_req = 1'b0;
    chk("busy_req_ignored", 64'(reg_req_out), 64'd0);
    tick();
    chk("busy_req_ignored2", 64'(reg_req_out), 64'd0);
    chk("still_busy", 64'(core_reg_busy), 64'd1);
    expect_ack(n + 6, 32'hCAFE_F00D, 1'b0, 1'b0);
    ret(SW'(SID), 23'h0000AA, 1'b1, 32'hCAFE_F00D);
    repeat (3) tick();
    chk("no_extra_issue", 64'(reg_req_out), 64'd0);
    chk("idle_after_busy_req", 64'(core_reg_busy), 64'd0);

`ifdef REG_RING_MASTER_TIMEOUT_EN
    // Return on the expiry cycle wins.
    txn(1'b1, 23'h000301, 32'h0, TO, 1'b1, 32'h0BAD_F00D,
        32'h0BAD_F00D, 1'b0);
    // No return: ack 17 cycles after req_out, then late return dropped.
    issue(1'b1, 23'h000300, 32'h0, n);
    q.push_back('{n + TO + 2, 32'hDEAD_BEEF, 1'b1, 1'b1});
    repeat (TO + 2) tick();
    repeat (4) tick();
    ret(SW'(SID), 23'h000300, 1'b1, 32'h7777_7777);
    chk("late_ret_busy", 64'(core_reg_busy), 64'd0);
    tick();
    chk("late_ret_busy2", 64'(core_reg_busy), 64'd0);
`else
    // Without the timeout the wait persists until a return.
    issue(1'b1, 23'h000300, 32'h0, n);
    repeat (40) tick();
    chk("wait_persist_busy", 64'(core_reg_busy), 64'd1);
    chk("wait_persist_to", 64'(core_reg_timeout), 64'd0);
    expect_ack(cyc + 1, 32'h7777_7777, 1'b0, 1'b0);
    ret(SW'(SID), 23'h000300, 1'b1, 32'h7777_7777);
    tick();
`endif

    // Reset two cycles into WAIT abandons the access.
    txn(1'b1, 23'h000040, 32'h0, 2, 1'b1, 32'h4444_4444,
        32'h4444_4444, 1'b0);
    issue(1'b1, 23'h000050, 32'h0, n);
    tick();
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_busy", 64'(core_reg_busy), 64'd0);
    chk("async_rst_req_out", 64'(reg_req_out), 64'd0);
    chk("async_rst_rd_data", 64'(core_reg_rd_data), 64'd0);
    chk("async_rst_ack", 64'(core_reg_ack), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    ret(SW'(SID), 23'h000050, 1'b1, 32'h9999_9999);
    repeat (3) tick();
    chk("post_rst_busy", 64'(core_reg_busy), 64'd0);

    // Block still works after the abandoned access.
    txn(1'b1, 23'h000060, 32'h0, 1, 1'b1, 32'h6060_6060,
        32'h6060_6060, 1'b0);

    repeat (5) tick();
    chk("pending_acks", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
